uart_rx_os: RTL and testbench

- Oversampling UART receiver: deserialises the asynchronous rx line into parallel bytes and feeds the UART interface RX queue through a valid/ready handshake.
- Adds 16x oversampling, 3-sample majority voting, false-start rejection, and framing and overrun flags.
- Sits between the board rx pin and the hwreg UART interface.

---
 rtl/uart_rx_os.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os -- oversampling UART receiver.
//
// Deserialises the asynchronous rx line into parallel words and presents them
// through a single-entry valid/ready output buffer. Each bit is sampled
// OVERSAMPLE times; the bit value is the majority of the three samples around
// the bit centre. A start bit that votes high is treated as a glitch and ignored.
//
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// between the data bits and the stop bit. Without it parity_err_o is tied to 0.
//
// Ports:
//   clk_i         core clock, rising edge
//   rst_i         synchronous active-high reset
//   rx_i          asynchronous serial input, idle high
//   ready_i       consumer accepts data_o this cycle when valid_o is high
//   valid_o       data_o holds an unread word
//   data_o        received word (first bit on the line lands in bit 0)
//   frame_err_o   one-cycle pulse: stop bit sampled low
//   overrun_o     one-cycle pulse: good word dropped because buffer was full
//   parity_err_o  one-cycle pulse with valid_o rising: parity mismatch

module uart_rx_os #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  parity_err_o
);

    localparam int SAMPLE_RATE = BAUD_RATE * OVERSAMPLE;
    localparam int DIV_ROUND   = (CLK_FREQ + SAMPLE_RATE / 2) / SAMPLE_RATE;
    localparam int DIV         = (DIV_ROUND < 1) ? 1 : DIV_ROUND;
    localparam int DCW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCW         = $clog2(OVERSAMPLE);
    localparam int BCW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int H           = OVERSAMPLE / 2;

    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [SCW-1:0] S_LAST   = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] S_A      = SCW'(H - 1);
    localparam logic [SCW-1:0] S_B      = SCW'(H);
    localparam logic [SCW-1:0] S_C      = SCW'(H + 1);
    localparam logic [BCW-1:0] B_LAST   = BCW'(DATA_WIDTH - 1);

    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_oversample
        $error("uart_rx_os: OVERSAMPLE must be even and >= 4");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } state_t;

    state_t state_reg, state_next;

    logic                  rx_meta_reg, rx_s_reg, rx_prev_reg;
    logic [DCW-1:0]        div_cnt_reg;
    logic [SCW-1:0]        samp_cnt_reg;
    logic [BCW-1:0]        bit_idx_reg;
    logic [2:0]            smp_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  valid_reg, frame_err_reg, overrun_reg;
    logic [DATA_WIDTH-1:0] data_reg;

    logic start_edge, tick, busy, bit_end, stop_tick, maj, stop_maj;
    logic deliver, frame_bad, par_flag;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign start_edge = (state_reg == ST_IDLE) && !rx_s_reg && rx_prev_reg;
    assign tick       = (div_cnt_reg == '0);
    assign busy       = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                        (state_reg == ST_PARITY) || (state_reg == ST_STOP);
    assign bit_end    = tick && (samp_cnt_reg == S_LAST);
    assign stop_tick  = tick && (samp_cnt_reg == S_C);
    assign maj        = majority3(smp_reg[0], smp_reg[1], smp_reg[2]);
    // The stop bit is judged on its last vote sample, so the third vote is the live rx_s.
    assign stop_maj   = majority3(smp_reg[0], smp_reg[1], rx_s_reg);

    // Two-flop synchroniser plus the previous synchronised value for edge detect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx_i;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start_edge) state_next = ST_START;
            ST_START:  if (bit_end) state_next = maj ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_end && bit_idx_reg == B_LAST)
`ifdef UART_RX_PARITY_EN
                           state_next = ST_PARITY;
            ST_PARITY: if (bit_end) state_next = ST_STOP;
`else
                           state_next = ST_STOP;
`endif
            ST_STOP:   if (stop_tick) state_next = stop_maj ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rx_s_reg) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs (frame completion events)
    always_comb begin
        deliver   = 1'b0;
        frame_bad = 1'b0;
        if (state_reg == ST_STOP && stop_tick) begin
            deliver   = stop_maj;
            frame_bad = !stop_maj;
        end
    end

    // Tick divider, sample counter, vote samples and data shifter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_reg  <= '0;
            samp_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            smp_reg      <= '0;
            shift_reg    <= '0;
        end else begin
            if (start_edge) begin
                // Realign the sampling phase to the falling edge of the start bit.
                div_cnt_reg  <= DIV_LAST;
                samp_cnt_reg <= '0;
            end else begin
                div_cnt_reg <= tick ? DIV_LAST : div_cnt_reg - 1'b1;
                if (tick && busy) begin
                    samp_cnt_reg <= (samp_cnt_reg == S_LAST) ? '0 : samp_cnt_reg + 1'b1;
                    if (samp_cnt_reg == S_A) smp_reg[0] <= rx_s_reg;
                    if (samp_cnt_reg == S_B) smp_reg[1] <= rx_s_reg;
                    if (samp_cnt_reg == S_C) smp_reg[2] <= rx_s_reg;
                end
            end
            if (state_reg == ST_START && bit_end) bit_idx_reg <= '0;
            if (state_reg == ST_DATA && bit_end) begin
                // LSB arrives first, so shift in from the top.
                shift_reg   <= {maj, shift_reg[DATA_WIDTH-1:1]};
                bit_idx_reg <= bit_idx_reg + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err_reg, parity_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) par_err_reg <= 1'b0;
        else if (state_reg == ST_PARITY && bit_end) par_err_reg <= (^shift_reg) ^ maj;
    end

    assign par_flag     = par_err_reg;
    assign parity_err_o = parity_reg;
`else
    assign par_flag     = 1'b0;
    assign parity_err_o = 1'b0;
`endif

    // Single-entry output buffer and flag pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg     <= 1'b0;
            data_reg      <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            frame_err_reg <= frame_bad;
            overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
            if (deliver) begin
                if (!valid_reg || ready_i) begin
                    valid_reg  <= 1'b1;
                    data_reg   <= shift_reg;
`ifdef UART_RX_PARITY_EN
                    parity_reg <= par_flag;
`endif
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && ready_i) begin
                valid_reg <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    logic unused_par;
    assign unused_par = par_flag;
`endif

    assign valid_o     = valid_reg;
    assign data_o      = data_reg;
    assign frame_err_o = frame_err_reg;
    assign overrun_o   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os: 32 MHz clock, 1 Mbaud, 16x oversampling (32 cycles/bit).
// Expected words are queued when a frame is sent; words accepted from the DUT are
// queued by a monitor, and each scenario task pops and compares the two.

module tb_uart_rx_os;

    localparam int DW      = 8;
    localparam int BIT_CYC = 32;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          rx_i = 1'b1;
    logic          ready_i = 1'b0;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          frame_err_o, overrun_o, parity_err_o;

    uart_rx_os #(
        .CLK_FREQ  (32_000_000),
        .BAUD_RATE (1_000_000),
        .DATA_WIDTH(DW),
        .OVERSAMPLE(16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int rise_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
    int rise_cyc = 0, start_cyc = 0, stable_viol = 0;
    logic rise_perr = 1'b0;
    logic valid_d = 1'b0, ready_d = 1'b0;
    logic [DW-1:0] data_d = '0;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid_o === 1'b1 && ready_i) got_q.push_back(data_o);
        if (valid_o === 1'b1 && !valid_d) begin
            rise_cnt  = rise_cnt + 1;
            rise_cyc  = cyc;
            rise_perr = parity_err_o;
        end
        if (valid_o === 1'b1 && valid_d && !ready_d && data_o !== data_d)
            stable_viol = stable_viol + 1;
        if (frame_err_o === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (overrun_o === 1'b1)   ovr_cnt  = ovr_cnt + 1;
        if (parity_err_o === 1'b1) perr_cnt = perr_cnt + 1;
        valid_d = (valid_o === 1'b1);
        ready_d = ready_i;
        data_d  = data_o;
    end

    // Drives one frame. The line is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop);
        @(negedge clk);
        rx_i = 1'b0;
        start_cyc = cyc;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rx_i = d[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        if (PBITS != 0) begin
            rx_i = par;
            repeat (BIT_CYC) @(negedge clk);
        end
        rx_i = stop;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        rx_i = 1'b1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else pass_cnt++;
        total_cnt++; if (data_o !== '0) $display("FAIL reset_data got=%h exp=00", data_o); else pass_cnt++;
        total_cnt++; if (frame_err_o !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", frame_err_o); else pass_cnt++;
        total_cnt++; if (overrun_o !== 1'b0) $display("FAIL reset_ovr got=%b exp=0", overrun_o); else pass_cnt++;
        total_cnt++; if (parity_err_o !== 1'b0) $display("FAIL reset_perr got=%b exp=0", parity_err_o); else pass_cnt++;
        rst_i = 1'b0;
        repeat (5) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single();
        int r0, f0, o0, lat;
        logic [DW-1:0] e, g;
        ready_i = 1'b1;
        r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, ^8'hA5, 1'b1);
        repeat (40) @(negedge clk);
        // Latency measured from the edge that registers the start bit
        // (third rising edge after rx_i falls: two synchroniser flops + detect).
        lat = rise_cyc - start_cyc - 3;
        total_cnt++;
        if (got_q.size() != 1) $display("FAIL single_count got=%0d exp=1", got_q.size());
        else begin
            pass_cnt++;
            e = exp_q.pop_front(); g = got_q.pop_front();
            total_cnt++; if (g !== e) $display("FAIL single_data got=%h exp=%h", g, e); else pass_cnt++;
        end
        total_cnt++; if (rise_cnt - r0 != 1) $display("FAIL single_rises got=%0d exp=1", rise_cnt - r0); else pass_cnt++;
        total_cnt++;
        if (lat < 302 + BIT_CYC * PBITS || lat > 308 + BIT_CYC * PBITS)
            $display("FAIL single_latency got=%0d exp=%0d..%0d", lat, 302 + BIT_CYC * PBITS, 308 + BIT_CYC * PBITS);
        else pass_cnt++;
        total_cnt++; if (ferr_cnt != f0 || ovr_cnt != o0) $display("FAIL single_flags got ferr=%0d ovr=%0d exp 0 0", ferr_cnt - f0, ovr_cnt - o0); else pass_cnt++;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL single_valid_pulse got=%b exp=0", valid_o); else pass_cnt++;
        $display("test_single: byte A5 latency=%0d", lat);
    endtask

    task automatic test_overrun();
        int o0;
        logic [DW-1:0] e, g;
        @(posedge clk); #1 ready_i = 1'b0;
        o0 = ovr_cnt;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        send_frame(8'hC3, ^8'hC3, 1'b1);
        repeat (10) @(negedge clk);
        total_cnt++; if (valid_o !== 1'b1) $display("FAIL ovr_valid got=%b exp=1", valid_o); else pass_cnt++;
        total_cnt++; if (data_o !== 8'h3C) $display("FAIL ovr_data_held got=%h exp=3c", data_o); else pass_cnt++;
        total_cnt++; if (ovr_cnt - o0 != 1) $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - o0); else pass_cnt++;
        total_cnt++; if (stable_viol != 0) $display("FAIL ovr_stable got=%0d exp=0", stable_viol); else pass_cnt++;
        @(posedge clk); #1 ready_i = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL ovr_valid_fall got=%b exp=0", valid_o); else pass_cnt++;
        total_cnt++;
        if (got_q.size() != 1) $display("FAIL ovr_count got=%0d exp=1", got_q.size());
        else begin
            pass_cnt++;
            e = exp_q.pop_front(); g = got_q.pop_front();
            total_cnt++; if (g !== e) $display("FAIL ovr_accept got=%h exp=%h", g, e); else pass_cnt++;
        end
        $display("test_overrun: 3C kept, C3 dropped");
    endtask

    task automatic test_glitch();
        int r0, f0, o0;
        logic [DW-1:0] e, g;
        r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        @(negedge clk); rx_i = 1'b0;
        repeat (10) @(negedge clk);
        rx_i = 1'b1;
        repeat (64) @(negedge clk);
        total_cnt++; if (rise_cnt != r0) $display("FAIL glitch_valid got=%0d exp=0", rise_cnt - r0); else pass_cnt++;
        total_cnt++; if (ferr_cnt != f0 || ovr_cnt != o0) $display("FAIL glitch_flags got ferr=%0d ovr=%0d exp 0 0", ferr_cnt - f0, ovr_cnt - o0); else pass_cnt++;
        exp_q.push_back(8'h55);
        send_frame(8'h55, ^8'h55, 1'b1);
        repeat (40) @(negedge clk);
        total_cnt++;
        if (got_q.size() != 1) $display("FAIL glitch_count got=%0d exp=1", got_q.size());
        else begin
            pass_cnt++;
            e = exp_q.pop_front(); g = got_q.pop_front();
            total_cnt++; if (g !== e) $display("FAIL glitch_next_data got=%h exp=%h", g, e); else pass_cnt++;
        end
        $display("test_glitch: 10-cycle glitch rejected, then 55");
    endtask

    task automatic test_break();
        int r0, f0;
        logic [DW-1:0] e, g;
        r0 = rise_cnt; f0 = ferr_cnt;
        send_frame(8'h81, ^8'h81, 1'b0);
        repeat (500) @(negedge clk);
        total_cnt++; if (ferr_cnt - f0 != 1) $display("FAIL break_ferr got=%0d exp=1", ferr_cnt - f0); else pass_cnt++;
        total_cnt++; if (rise_cnt != r0) $display("FAIL break_valid got=%0d exp=0", rise_cnt - r0); else pass_cnt++;
        rx_i = 1'b1;
        repeat (64) @(negedge clk);
        exp_q.push_back(8'h12);
        send_frame(8'h12, ^8'h12, 1'b1);
        repeat (40) @(negedge clk);
        total_cnt++;
        if (got_q.size() != 1) $display("FAIL break_count got=%0d exp=1", got_q.size());
        else begin
            pass_cnt++;
            e = exp_q.pop_front(); g = got_q.pop_front();
            total_cnt++; if (g !== e) $display("FAIL break_next_data got=%h exp=%h", g, e); else pass_cnt++;
        end
        total_cnt++; if (ferr_cnt - f0 != 1) $display("FAIL break_ferr_total got=%0d exp=1", ferr_cnt - f0); else pass_cnt++;
        $display("test_break: one frame error, then 12");
    endtask

    task automatic test_reset_mid();
        int f0;
        logic [DW-1:0] e, g;
        fork
            send_frame(8'hFF, ^8'hFF, 1'b1);
            begin
                repeat (BIT_CYC * 5 + 16) @(negedge clk);
                rst_i = 1'b1;
                @(posedge clk); #1;
                total_cnt++; if (valid_o !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", valid_o); else pass_cnt++;
                total_cnt++; if (data_o !== '0) $display("FAIL midrst_data got=%h exp=00", data_o); else pass_cnt++;
                rst_i = 1'b0;
            end
        join
        rx_i = 1'b1;
        repeat (40) @(negedge clk);
        f0 = ferr_cnt;
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, ^8'h0F, 1'b1);
        repeat (40) @(negedge clk);
        total_cnt++;
        if (got_q.size() != 1) $display("FAIL midrst_count got=%0d exp=1", got_q.size());
        else begin
            pass_cnt++;
            e = exp_q.pop_front(); g = got_q.pop_front();
            total_cnt++; if (g !== e) $display("FAIL midrst_next_data got=%h exp=%h", g, e); else pass_cnt++;
        end
        total_cnt++; if (ferr_cnt != f0) $display("FAIL midrst_ferr got=%0d exp=0", ferr_cnt - f0); else pass_cnt++;
        $display("test_reset_mid: partial FF discarded, then 0F");
    endtask

    task automatic test_parity();
        logic [DW-1:0] e, g;
        // 0x07 has three ones: even parity bit must be 1; sending 0 is an error.
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(8'h07);
            send_frame(8'h07, (k == 1), 1'b1);
            repeat (40) @(negedge clk);
            total_cnt++;
            if (got_q.size() != 1) $display("FAIL parity_count got=%0d exp=1", got_q.size());
            else begin
                pass_cnt++;
                e = exp_q.pop_front(); g = got_q.pop_front();
                total_cnt++; if (g !== e) $display("FAIL parity_data got=%h exp=%h", g, e); else pass_cnt++;
            end
            total_cnt++;
            if (rise_perr !== (k == 0)) $display("FAIL parity_flag pbit=%0d got=%b exp=%b", k, rise_perr, (k == 0));
            else pass_cnt++;
            $display("test_parity: 07 parity bit %0d", k);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_glitch();
        test_break();
        test_reset_mid();
        if (PBITS != 0) test_parity();
        total_cnt++; if (exp_q.size() != got_q.size()) $display("FAIL leftover got=%0d exp=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
